walsh_index_gen: RTL and testbench

//  Parametrised measurement-index generator for the FWHT datapath; successor of the fixed 6-bit sequency counter.

---
 rtl/walsh_index_gen_if.sv | 30 +++
 rtl/walsh_index_gen.sv | 143 ++++++++++++++
 tb/tb_walsh_index_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/walsh_index_gen_if.sv
// Stream and control bundle between the measurement controller, the index
// generator and the pattern/coefficient address path.
interface walsh_index_gen_if #(
  parameter int L_WIDTH = 6
) ();
  // Handshake: the generator raises valid with index/seq/last and holds all
  // three stable until a cycle where valid & ready (and clock enable) are
  // high; valid is never withdrawn before that transfer.
  logic               start;
  logic [1:0]         mode;
  logic [L_WIDTH:0]   count;
  logic               valid;
  logic               ready;
  logic [L_WIDTH-1:0] index;
  logic [L_WIDTH-1:0] seq;
  logic               last;
  logic               busy;
  logic               done;
  logic               dbg_state;

  modport master (
    input  start, mode, count, ready,
    output valid, index, seq, last, busy, done, dbg_state
  );

  modport slave (
    output start, mode, count, ready,
    input  valid, index, seq, last, busy, done, dbg_state
  );
endinterface

// File: rtl/walsh_index_gen.sv
// Burst generator of Walsh-Hadamard row indices in natural, dyadic, sequency
// or gray order, streamed one beat per accepted transfer.
module walsh_index_gen #(
  parameter int L_WIDTH  = 6,
  parameter int MEASURES = 2 ** L_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  walsh_index_gen_if.master  bus
);

  localparam int N = 2 ** L_WIDTH;
  localparam logic [L_WIDTH:0] N_C        = (L_WIDTH + 1)'(N);
  localparam logic [L_WIDTH:0] MEASURES_C = (L_WIDTH + 1)'(MEASURES);
  localparam logic [L_WIDTH:0] ONE_C      = (L_WIDTH + 1)'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [L_WIDTH:0]   cnt_q, cnt_d;
  logic [L_WIDTH:0]   k_q, k_d;
  logic [L_WIDTH-1:0] index_q, index_d;
  logic [L_WIDTH-1:0] seq_q, seq_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic               start_ok;
  logic               xfer;
  logic               final_xfer;
  logic [L_WIDTH:0]   eff_count;

  function automatic logic [L_WIDTH-1:0] bitrev(input logic [L_WIDTH-1:0] v);
    logic [L_WIDTH-1:0] r;
    for (int b = 0; b < L_WIDTH; b++) r[b] = v[L_WIDTH-1-b];
    return r;
  endfunction

  function automatic logic [L_WIDTH-1:0] map_index(input logic [1:0] m,
                                                   input logic [L_WIDTH-1:0] k);
    logic [L_WIDTH-1:0] g;
    g = k ^ (k >> 1);
    case (m)
      2'd0:    return k;
      2'd1:    return bitrev(k);
      2'd2:    return bitrev(g);
      default: return g;
    endcase
  endfunction

  // The cycle carrying the done pulse still blocks a start, so a new burst
  // can only be requested once done has dropped.
  assign start_ok   = (state_q == IDLE) && bus.start && !done_q;
  assign xfer       = (state_q == RUN) && bus.ready;
  assign final_xfer = xfer && last_q;

  always_comb begin
    eff_count = bus.count;
    if (bus.count == '0)      eff_count = MEASURES_C;
    else if (bus.count > N_C) eff_count = N_C;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset)   state_q <= IDLE;
    else if (i_ce) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = RUN;
      RUN:     if (final_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next beat datapath: index/seq/last are computed one cycle ahead so the
  // outputs come straight from flops.
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    index_d = index_q;
    seq_d   = seq_q;
    last_d  = last_q;
    done_d  = final_xfer;
    if (start_ok) begin
      mode_d  = bus.mode;
      cnt_d   = eff_count;
      k_d     = '0;
      index_d = '0;
      seq_d   = '0;
      last_d  = (eff_count == ONE_C);
    end else if (xfer) begin
      if (last_q) begin
        k_d     = '0;
        index_d = '0;
        seq_d   = '0;
        last_d  = 1'b0;
      end else begin
        k_d     = k_q + ONE_C;
        index_d = map_index(mode_q, k_d[L_WIDTH-1:0]);
        seq_d   = k_d[L_WIDTH-1:0];
        last_d  = (k_d == cnt_q - ONE_C);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      index_q <= '0;
      seq_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_ce) begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      index_q <= index_d;
      seq_q   <= seq_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Output logic
  always_comb begin
    bus.valid     = (state_q == RUN);
    bus.busy      = (state_q == RUN);
    bus.index     = index_q;
    bus.seq       = seq_q;
    bus.last      = last_q;
    bus.done      = done_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_walsh_index_gen.sv
// Bench for walsh_index_gen: directed bursts plus randomized ready/enable
// traffic checked against an arithmetic ordering model.
module tb_walsh_index_gen;
  localparam int L  = 3;
  localparam int N  = 8;
  localparam int W  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic ce6;
  always #5 clk = ~clk;

  walsh_index_gen_if #(.L_WIDTH(3)) bus ();
  walsh_index_gen_if #(.L_WIDTH(6)) bus6 ();

  walsh_index_gen #(.L_WIDTH(3), .MEASURES(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .bus(bus)
  );

  walsh_index_gen #(.L_WIDTH(6), .MEASURES(64)) dut6 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce6), .bus(bus6)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference ordering model
  function automatic int ref_bitrev(input int v, input int w);
    int r = 0;
    for (int b = 0; b < w; b++)
      if (((v >> b) & 1) == 1) r += 1 << (w - 1 - b);
    return r;
  endfunction

  function automatic int ref_index(input int mode, input int k, input int w);
    int g = k ^ (k / 2);
    case (mode)
      0:       return k;
      1:       return ref_bitrev(k, w);
      2:       return ref_bitrev(g, w);
      default: return g;
    endcase
  endfunction

  task automatic fill_model(input int mode, input int count);
    int c;
    c = (count == 0) ? N : ((count > N) ? N : count);
    exp_q.delete();
    for (int k = 0; k < c; k++) exp_q.push_back(W'(ref_index(mode, k, L)));
  endtask

  // driver: ready_pct < 0 selects the fixed ready pattern
  task automatic run_queued(input int mode, input int count, input int ready_pct,
                            input int ce_pct, input bit noise, input string tag);
    int  k;
    int  cycles;
    bit  r;
    bit  e;
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(bus.valid), 0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    bus.start = 1'b1;
    bus.mode  = 2'(mode);
    bus.count = 4'(count);
    bus.ready = 1'b0;
    ce        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 400) begin
      chk({tag, "_valid"}, 32'(bus.valid), 1);
      chk({tag, "_busy"}, 32'(bus.busy), 1);
      chk({tag, "_index"}, 32'(bus.index), 32'(exp_q[0]));
      chk({tag, "_seq"}, 32'(bus.seq), 32'(k));
      chk({tag, "_last"}, 32'(bus.last), (exp_q.size() == 1) ? 1 : 0);
      chk({tag, "_done_mid"}, 32'(bus.done), 0);
      if (ready_pct < 0) r = rdy_pat[cycles % 6];
      else               r = ($urandom_range(99) < 32'(ready_pct));
      e = ($urandom_range(99) < 32'(ce_pct));
      bus.ready = r;
      ce = e;
      if (noise) begin
        bus.start = 1'($urandom_range(1));
        bus.mode  = 2'($urandom_range(3));
        bus.count = 4'($urandom_range(15));
      end
      @(negedge clk);
      cycles++;
      if (r && e) begin
        void'(exp_q.pop_front());
        k++;
      end
    end
    if (exp_q.size() > 0) chk({tag, "_timeout"}, 32'(exp_q.size()), 0);
    chk({tag, "_done_pulse"}, 32'(bus.done), 1);
    chk({tag, "_end_valid"}, 32'(bus.valid), 0);
    chk({tag, "_end_busy"}, 32'(bus.busy), 0);
    bus.ready = 1'b0;
    bus.start = 1'b1;
    ce        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_start_on_done_ignored"}, 32'(bus.valid), 0);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[4][8];
    tbl[0] = '{0, 1, 2, 3, 4, 5, 6, 7};
    tbl[1] = '{0, 4, 2, 6, 1, 5, 3, 7};
    tbl[2] = '{0, 4, 6, 2, 3, 7, 5, 1};
    tbl[3] = '{0, 1, 3, 2, 6, 7, 5, 4};

    rst = 1'b1; ce = 1'b1; ce6 = 1'b1;
    bus.start = 1'b0; bus.mode = '0; bus.count = '0; bus.ready = 1'b0;
    bus6.start = 1'b0; bus6.mode = '0; bus6.count = '0; bus6.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_index", 32'(bus.index), 0);
    chk("rst_seq", 32'(bus.seq), 0);
    chk("rst_last", 32'(bus.last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    // literal orderings for L_WIDTH=3, full-length bursts
    for (int m = 0; m < 4; m++) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(W'(tbl[m][i]));
      run_queued(m, (m == 2) ? 0 : 8, 100, 100, 1'b0, $sformatf("table_m%0d", m));
    end

    // fixed ready pattern, count 3
    fill_model(2, 3);
    run_queued(2, 3, -1, 100, 1'b0, "ready_pattern");

    // enable gaps with start/mode/count noise during the burst
    fill_model(1, 0);
    run_queued(1, 0, 100, 50, 1'b1, "ce_gaps");

    // single beat and clamp
    for (int m = 0; m < 4; m++) begin
      fill_model(m, 1);
      run_queued(m, 1, 100, 100, 1'b0, $sformatf("count1_m%0d", m));
    end
    fill_model(3, 12);
    run_queued(3, 12, 100, 100, 1'b0, "clamp12");

    // reset mid-burst
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd2; bus.count = '0; bus.ready = 1'b1; ce = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_index", 32'(bus.index), 32'(ref_index(2, i, L)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ready = 1'b0;
    chk("rstmid_valid", 32'(bus.valid), 0);
    chk("rstmid_index0", 32'(bus.index), 0);
    chk("rstmid_done", 32'(bus.done), 0);
    @(negedge clk);
    chk("rstmid_no_done", 32'(bus.done), 0);
    chk("rstmid_idle", 32'(bus.valid), 0);
    fill_model(2, 0);
    run_queued(2, 0, 100, 100, 1'b0, "after_reset");

    // randomized bursts
    for (int t = 0; t < 24; t++) begin
      int m;
      int c;
      m = int'($urandom_range(3));
      c = int'($urandom_range(15));
      fill_model(m, c);
      run_queued(m, c, int'($urandom_range(100, 30)), int'($urandom_range(100, 60)),
                 1'($urandom_range(1)), $sformatf("rand%0d", t));
    end

    // wide instance, sequency order
    @(negedge clk);
    bus6.start = 1'b1; bus6.mode = 2'd2; bus6.count = '0; bus6.ready = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w6_index_k%0d", i), 32'(bus6.index), 32'(ref_index(2, i, 6)));
      if (i == 1) chk("w6_k1_is_32", 32'(bus6.index), 32);
      if (i == 2) chk("w6_k2_is_48", 32'(bus6.index), 48);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("w6_rst_valid", 32'(bus6.valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
